// File: rtl/nlc_ch_sequencer.sv
// nlc_ch_sequencer: initiator side of one nonlinear-correction channel.
// Takes ADC samples from an upstream valid/ready stream and launches one
// correction per sample. It holds x_adc for the whole conversion window and
// collects x_lin into a show-ahead output FIFO. It also enforces window
// spacing and flags windows that close without a result.
//
// state | meaning
// IDLE  | no sample in flight; accepts a sample when the FIFO has room
// BUSY  | conversion window open; x_adc held, first srdyo captured
module nlc_ch_sequencer #(
  parameter int DATA_W     = 21,
  parameter int FIFO_DEPTH = 4,
  parameter int WINDOW     = 260,
  parameter int CNT_W      = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] nlc_x_adc,
  output logic              nlc_srdyi,
  input  logic [DATA_W-1:0] nlc_x_lin,
  input  logic              nlc_srdyo,
  output logic              busy,
  output logic              err_timeout,
  input  logic              clear_err,
  output logic [7:0]        drop_cnt
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic                got_result_q, got_result_d;
  logic [DATA_W-1:0]   x_adc_q, x_adc_d;
  logic                srdyi_q, srdyi_d;
  logic                err_q, err_d;
  logic [7:0]          drop_q, drop_d;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]   count_q, count_d;

  logic                push;
  logic                pop;
  logic                timeout;

  assign in_ready    = (state_q == IDLE) && (count_q < DEPTH_C);
  assign busy        = (state_q == BUSY);
  assign nlc_x_adc   = x_adc_q;
  assign nlc_srdyi   = srdyi_q;
  assign err_timeout = err_q;
  assign drop_cnt    = drop_q;
  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign pop         = out_valid && out_ready;

  // Sequencer next state: launch on handshake, capture first result, close window.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    got_result_d = got_result_q;
    x_adc_d      = x_adc_q;
    srdyi_d      = 1'b0;
    push         = 1'b0;
    timeout      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_adc_d      = in_data;
          srdyi_d      = 1'b1;
          timer_d      = '0;
          got_result_d = 1'b0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        timer_d = timer_q + CNT_W'(1);
        // Only the first strobe of a window carries a result; repeats are noise.
        if (nlc_srdyo && !got_result_q) begin
          push         = 1'b1;
          got_result_d = 1'b1;
        end
        if (timer_q == WIN_LAST) begin
          state_d = IDLE;
          timer_d = '0;
          if (!got_result_q && !nlc_srdyo) begin
            timeout = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Error flag and drop counter; a timeout outranks a same-cycle clear.
  always_comb begin
    err_d  = err_q;
    drop_d = drop_q;
    if (clear_err) begin
      err_d  = 1'b0;
      drop_d = '0;
    end
    if (timeout) begin
      err_d = 1'b1;
      if (drop_d != 8'hFF) begin
        drop_d = drop_d + 8'd1;
      end
    end
  end

  // Sequencer and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      got_result_q <= 1'b0;
      x_adc_q      <= '0;
      srdyi_q      <= 1'b0;
      err_q        <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      got_result_q <= got_result_d;
      x_adc_q      <= x_adc_d;
      srdyi_q      <= srdyi_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
    end
  end

  // FIFO occupancy; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= nlc_x_lin;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_nlc_ch_sequencer.sv
// Directed bench for nlc_ch_sequencer with a behavioural channel responder.
module tb_nlc_ch_sequencer;

  localparam int DW = 21;
  localparam logic [DW-1:0] MASK  = 21'h0A5A5A;
  localparam logic [DW-1:0] MASK2 = 21'h1F0F0F;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [DW-1:0] nlc_x_adc;
  logic          nlc_srdyi;
  logic [DW-1:0] nlc_x_lin;
  logic          nlc_srdyo;
  logic          busy;
  logic          err_timeout;
  logic          clear_err;
  logic [7:0]    drop_cnt;

  logic          resp_srdyo;
  logic          spur_srdyo;
  logic [DW-1:0] resp_xlin;
  assign nlc_srdyo = resp_srdyo | spur_srdyo;
  assign nlc_x_lin = resp_xlin;

  nlc_ch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .nlc_x_adc  (nlc_x_adc),
    .nlc_srdyi  (nlc_srdyi),
    .nlc_x_lin  (nlc_x_lin),
    .nlc_srdyo  (nlc_srdyo),
    .busy       (busy),
    .err_timeout(err_timeout),
    .clear_err  (clear_err),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // responder controls
  bit          resp_en = 1'b1;
  bit          resp_fixed_en = 1'b0;
  bit          resp_dup = 1'b0;
  logic [DW-1:0] resp_fixed = '0;
  int          resp_delay = 10;

  // channel model: answers k cycles after srdyi with a fixed value or x_adc^MASK
  initial begin
    int k;
    bit act;
    logic [DW-1:0] ax;
    resp_srdyo = 1'b0;
    resp_xlin  = '0;
    act = 1'b0;
    k = 0;
    ax = '0;
    forever begin
      @(posedge clk);
      #2;
      resp_srdyo = 1'b0;
      if (nlc_srdyi) begin
        act = 1'b1;
        k   = 0;
        ax  = nlc_x_adc;
      end else if (act) begin
        k++;
        if (resp_en && k == resp_delay) begin
          resp_srdyo = 1'b1;
          resp_xlin  = resp_fixed_en ? resp_fixed : (ax ^ MASK);
        end else if (resp_en && resp_dup && k == resp_delay + 10) begin
          resp_srdyo = 1'b1;
          resp_xlin  = ax ^ MASK2;
          act = 1'b0;
        end
      end
    end
  end

  // monitor: launches, pops, window length, in_ready and x_adc during BUSY
  int            cyc = 0;
  int            launches[$];
  logic [DW-1:0] outq[$];
  int            run = 0;
  int            last_run = 0;
  int            inrdy_viol = 0;
  int            xadc_viol = 0;
  logic [DW-1:0] launch_x = '0;
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (nlc_srdyi) begin
        launches.push_back(cyc);
        launch_x = nlc_x_adc;
      end
      if (busy && in_ready) inrdy_viol++;
      if (busy && nlc_x_adc != launch_x) xadc_viol++;
      if (out_valid && out_ready) outq.push_back(out_data);
      if (busy) run++;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy_low(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_in_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 1000) begin
      step();
      n++;
    end
    chk(tag, 32'(in_ready), 32'd1);
  endtask

  task automatic wait_out_valid(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 1000) begin
      step();
      n++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  logic [DW-1:0] smp [9];
  int n;

  initial begin
    smp[0] = 21'h1FFF00; smp[1] = 21'h000001; smp[2] = 21'h100000;
    smp[3] = 21'h0FFFFF; smp[4] = 21'h012345; smp[5] = 21'h1ABCDE;
    smp[6] = 21'h054321; smp[7] = 21'h1FFFFF; smp[8] = 21'h00ACE1;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    clear_err = 1'b0; spur_srdyo = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_srdyi", 32'(nlc_srdyi), 0);
    chk("rst_x_adc", 32'(nlc_x_adc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    reset = 1'b1;
    step();

    // single sample
    resp_fixed_en = 1'b1; resp_fixed = 21'h000123; resp_delay = 40;
    in_valid = 1'b1; in_data = smp[0];
    chk("t1_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("t1_srdyi_hi", 32'(nlc_srdyi), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_x_adc", 32'(nlc_x_adc), 32'h1FFF00);
    step();
    chk("t1_srdyi_lo", 32'(nlc_srdyi), 0);
    wait_out_valid("t1_wait_ov", n);
    chk("t1_ov_latency", 32'(n), 40);
    chk("t1_out_data", 32'(out_data), 32'h000123);
    wait_busy_low("t1_wait_idle");
    step();
    chk("t1_window_len", 32'(last_run), 260);
    chk("t1_x_adc_hold", 32'(xadc_viol), 0);
    chk("t1_err", 32'(err_timeout), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_pop_empty", 32'(out_valid), 0);

    // back-to-back launches with in_valid held
    resp_fixed_en = 1'b0; resp_delay = 10;
    out_ready = 1'b1;
    launches.delete(); outq.delete();
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = smp[i];
      wait_in_ready("t2_wait_ready");
      step();
    end
    in_valid = 1'b0;
    wait_busy_low("t2_wait_idle");
    repeat (3) step();
    chk("t2_launches", 32'(launches.size()), 3);
    if (launches.size() == 3) begin
      chk("t2_space01", 32'(launches[1] - launches[0]), 261);
      chk("t2_space12", 32'(launches[2] - launches[1]), 261);
    end
    chk("t2_outs", 32'(outq.size()), 3);
    for (int i = 0; i < 3 && i < outq.size(); i++)
      chk("t2_out_data", 32'(outq[i]), 32'(smp[i+1] ^ MASK));
    chk("t2_in_ready_busy", 32'(inrdy_viol), 0);
    out_ready = 1'b0;

    // timeouts, saturating count path, clear priority
    resp_en = 1'b0;
    in_valid = 1'b1; in_data = smp[2];
    step();
    in_valid = 1'b0;
    step();
    chk("t3_err_early", 32'(err_timeout), 0);
    wait_busy_low("t3_wait_idle");
    chk("t3_err", 32'(err_timeout), 1);
    chk("t3_drop1", 32'(drop_cnt), 1);
    chk("t3_fifo_empty", 32'(out_valid), 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_busy_low("t3_wait_idle2");
    chk("t3_drop2", 32'(drop_cnt), 2);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (259) step();
    chk("t3_still_busy", 32'(busy), 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("t3_exit", 32'(busy), 0);
    chk("t3_clr_vs_to_err", 32'(err_timeout), 1);
    chk("t3_clr_vs_to_drop", 32'(drop_cnt), 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("t3_clr_err", 32'(err_timeout), 0);
    chk("t3_clr_drop", 32'(drop_cnt), 0);
    resp_en = 1'b1;

    // backpressure: four results fill the FIFO, fifth waits for a pop
    resp_delay = 5;
    outq.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = smp[i+1];
      wait_in_ready("t4_wait_ready");
      step();
    end
    in_data = smp[5];
    wait_busy_low("t4_wait_idle");
    step();
    chk("t4_in_ready_full", 32'(in_ready), 0);
    chk("t4_head", 32'(out_data), 32'(smp[1] ^ MASK));
    repeat (20) step();
    chk("t4_no_launch", 32'(busy), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_ready_after_pop", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("t4_fifth_launch", 32'(nlc_srdyi), 1);
    chk("t4_fifth_x_adc", 32'(nlc_x_adc), 32'(smp[5]));
    wait_busy_low("t4_wait_idle2");
    out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    chk("t4_outs", 32'(outq.size()), 5);
    for (int i = 0; i < 5 && i < outq.size(); i++)
      chk("t4_order", 32'(outq[i]), 32'(smp[i+1] ^ MASK));
    chk("t4_drained", 32'(out_valid), 0);

    // duplicate strobe in window, spurious strobe in IDLE
    resp_dup = 1'b1; resp_delay = 10;
    in_valid = 1'b1; in_data = smp[6];
    step();
    in_valid = 1'b0;
    wait_busy_low("t5_wait_idle");
    resp_dup = 1'b0;
    chk("t5_one_push", 32'(out_data), 32'(smp[6] ^ MASK));
    spur_srdyo = 1'b1;
    step();
    spur_srdyo = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t5_only_one", 32'(out_valid), 0);
    chk("t5_no_err", 32'(err_timeout), 0);

    // asynchronous reset in the middle of a window
    resp_delay = 5;
    in_valid = 1'b1; in_data = smp[7];
    step();
    in_valid = 1'b0;
    wait_busy_low("t6_wait_idle");
    resp_delay = 150;
    in_valid = 1'b1; in_data = smp[8];
    step();
    in_valid = 1'b0;
    repeat (100) step();
    chk("t6_pre_busy", 32'(busy), 1);
    chk("t6_pre_ov", 32'(out_valid), 1);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_srdyi", 32'(nlc_srdyi), 0);
    chk("t6_rst_ov", 32'(out_valid), 0);
    chk("t6_rst_od", 32'(out_data), 0);
    chk("t6_rst_x_adc", 32'(nlc_x_adc), 0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("t6_idle_ready", 32'(in_ready), 1);
    chk("t6_idle_busy", 32'(busy), 0);
    resp_delay = 20;
    in_valid = 1'b1; in_data = smp[4];
    step();
    in_valid = 1'b0;
    chk("t6_relaunch", 32'(nlc_srdyi), 1);
    chk("t6_relaunch_x", 32'(nlc_x_adc), 32'(smp[4]));
    wait_out_valid("t6_wait_ov", n);
    chk("t6_ov_latency", 32'(n), 21);
    chk("t6_out_data", 32'(out_data), 32'(smp[4] ^ MASK));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
